// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, with sign fix-up and a registered writeback.
module muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [WIDTH-1:0]  opA,
  input  logic [WIDTH-1:0]  opB,
  input  logic [ADDR_W-1:0] rdAddrIn,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              rdWrite,
  output logic [ADDR_W-1:0] rdAddrOut
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic              neg_a_q, neg_b_q;
  logic [WIDTH:0]    hi_q;
  logic [WIDTH-1:0]  lo_q;
  logic [WIDTH-1:0]  dvsr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              special_q;
  logic [WIDTH-1:0]  special_val_q;

  logic              sgn_a, sgn_b, b_zero, ovf, special_in;
  logic [WIDTH-1:0]  mag_a, mag_b, special_val;

  // Operand decode on the raw inputs, used only when a start is accepted.
  always_comb begin
    sgn_a = opA[WIDTH-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                            (funct3 == 3'b100) | (funct3 == 3'b110));
    sgn_b = opB[WIDTH-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                            (funct3 == 3'b110));
    mag_a = sgn_a ? (~opA + 1'b1) : opA;
    mag_b = sgn_b ? (~opB + 1'b1) : opB;
    b_zero = (opB == '0);
    ovf = funct3[2] & ~funct3[0] & (opA == MIN_VAL) & (opB == {WIDTH{1'b1}});
    special_in = funct3[2] & (b_zero | ovf);
    special_val = '0;
    if (b_zero) begin
      special_val = funct3[1] ? opA : {WIDTH{1'b1}};
    end else if (ovf) begin
      special_val = funct3[1] ? '0 : MIN_VAL;
    end
  end

  logic [WIDTH:0] add_sum, shifted, diff;
  logic           fits;

  always_comb begin
    add_sum = hi_q + (lo_q[0] ? {1'b0, dvsr_q} : '0);
    shifted = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_q};
    fits    = (shifted >= {1'b0, dvsr_q});
  end

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, final_val;

  // Sign fix-up: product negated as a whole, quotient by sign XOR, remainder follows dividend.
  always_comb begin
    prod   = {hi_q[WIDTH-1:0], lo_q};
    prod_s = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;
    quo_s  = (neg_a_q ^ neg_b_q) ? (~lo_q + 1'b1) : lo_q;
    rem_s  = neg_a_q ? (~hi_q[WIDTH-1:0] + 1'b1) : hi_q[WIDTH-1:0];
    case (op_q)
      3'b000:                 final_val = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         final_val = quo_s;
      default:                final_val = rem_s;
    endcase
    if (special_q) final_val = special_val_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = special_in ? DONE : CALC;
      CALC:    if (cnt_q == LAST_CNT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_comb begin
    busy  = (state != IDLE);
    stall = ((state == IDLE) && start) || (state == CALC);
  end

  assign rdWrite = done;

  // Datapath: latch in IDLE, iterate in CALC, register the writeback in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      done          <= 1'b0;
      result        <= '0;
      rdAddrOut     <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      neg_a_q       <= 1'b0;
      neg_b_q       <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      dvsr_q        <= '0;
      cnt_q         <= '0;
      special_q     <= 1'b0;
      special_val_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q          <= funct3;
            rd_q          <= rdAddrIn;
            neg_a_q       <= sgn_a;
            neg_b_q       <= sgn_b;
            hi_q          <= '0;
            lo_q          <= funct3[2] ? mag_a : mag_b;
            dvsr_q        <= funct3[2] ? mag_b : mag_a;
            cnt_q         <= '0;
            special_q     <= special_in;
            special_val_q <= special_val;
          end
        end
        CALC: begin
          if (op_q[2]) begin
            if (fits) begin
              hi_q <= diff;
              lo_q <= {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_q <= shifted;
              lo_q <= {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi_q <= {1'b0, add_sum[WIDTH:1]};
            lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          if (!flush) begin
            done      <= 1'b1;
            result    <= final_val;
            rdAddrOut <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit: results, latency, stall, flush and reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [2:0]  funct3;
  logic [31:0] opA, opB;
  logic [4:0]  rdAddrIn;
  logic        stall, busy, done, rdWrite;
  logic [31:0] result;
  logic [4:0]  rdAddrOut;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  rd_q[$];
  logic [31:0] last_res;

  muldiv_unit #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .funct3(funct3),
    .opA(opA), .opB(opB), .rdAddrIn(rdAddrIn), .stall(stall), .busy(busy),
    .done(done), .result(result), .rdWrite(rdWrite), .rdAddrOut(rdAddrOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (f)
      3'd0: p = ua * ub;
      3'd1: p = sa * sb;
      3'd2: p = sa * $signed(ub);
      3'd3: p = ua * ub;
      default: ;
    endcase
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done was seen (or the bound expired).
  task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expv,
                       input bit special);
    int k, stalls;
    logic [31:0] e;
    logic [4:0]  er;
    exp_q.push_back(expv);
    rd_q.push_back(rd);
    funct3 = f; opA = a; opB = b; rdAddrIn = rd; start = 1'b1;
    #1 stalls = int'(stall);
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
      if (stall) stalls++;
    end
    check({tag, "_latency"}, k, special ? 2 : 34);
    check({tag, "_stall_cycles"}, stalls, special ? 1 : 33);
    e  = exp_q.pop_front();
    er = rd_q.pop_front();
    if (done) begin
      check({tag, "_result"}, result, e);
      check({tag, "_rd"}, 32'(rdAddrOut), 32'(er));
      check({tag, "_rdwrite"}, 32'(rdWrite), 32'd1);
      last_res = e;
    end
  endtask

  task automatic no_done(input string tag, input int n);
    int c = 0;
    repeat (n) begin
      @(negedge clk);
      if (done || rdWrite) c++;
    end
    check(tag, c, 0);
  endtask

  initial begin
    int k;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [31:0] edge_vals[4];
    bit sp;
    edge_vals[0] = 32'h8000_0000; edge_vals[1] = 32'hFFFF_FFFF;
    edge_vals[2] = 32'h0000_0000; edge_vals[3] = 32'h7FFF_FFFF;

    rst = 1'b1; flush = 1'b0; start = 1'b0; funct3 = '0; opA = '0; opB = '0; rdAddrIn = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_rdwrite", 32'(rdWrite), 0);
    check("reset_result", result, 0);
    check("reset_rdaddr", 32'(rdAddrOut), 0);
    check("reset_stall", 32'(stall), 0);

    issue("mul_7x6", 3'b000, 32'd7, 32'd6, 5'd5, 32'd42, 1'b0);
    @(negedge clk);
    check("done_pulse_width", 32'(done), 0);
    check("rdwrite_pulse_width", 32'(rdWrite), 0);
    check("result_hold", result, 32'd42);

    issue("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 1'b0);
    issue("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b0);
    issue("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 1'b0);
    issue("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 1'b0);
    issue("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0);
    issue("divu", 3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 1'b0);
    issue("remu", 3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 1'b0);
    issue("divu_by0", 3'b101, 32'h0000_BEEF, 32'd0, 5'd9, 32'hFFFF_FFFF, 1'b1);
    issue("rem_by0", 3'b110, 32'h0000_1234, 32'd0, 5'd10, 32'h0000_1234, 1'b1);
    issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1);
    issue("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b1);
    issue("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 5'd12, 32'hFFFF_FFF1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      sp = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      issue("random", f, a, b, 5'($urandom_range(0, 31)), model(f, a, b), sp);
    end

    // Flush in the middle of CALC: no writeback, result untouched.
    funct3 = 3'b000; opA = 32'h0001_2345; opB = 32'h0000_0777; rdAddrIn = 5'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(busy), 0);
    check("flush_result_kept", result, last_res);
    no_done("flush_no_done", 40);
    check("flush_result_still", result, last_res);

    // Start while busy is ignored.
    exp_q.push_back(32'd100);
    rd_q.push_back(5'd14);
    funct3 = 3'b101; opA = 32'd1000; opB = 32'd10; rdAddrIn = 5'd14; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    repeat (5) begin @(negedge clk); k++; end
    funct3 = 3'b000; opA = 32'd3; opB = 32'd3; rdAddrIn = 5'd15; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!done && k < 100) begin @(negedge clk); k++; end
    check("swb_latency", k, 34);
    a = exp_q.pop_front();
    f = 3'(rd_q.pop_front());
    check("swb_result", result, a);
    check("swb_rd", 32'(rdAddrOut), 32'd14);
    no_done("swb_no_second_done", 40);

    // Reset in the middle of CALC.
    funct3 = 3'b011; opA = 32'hDEAD_BEEF; opB = 32'h1234_5678; rdAddrIn = 5'd16; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_result", result, 0);
    check("rst_mid_rdaddr", 32'(rdAddrOut), 0);
    no_done("rst_mid_no_done", 40);

    issue("after_rst_mulhu", 3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17,
          model(3'b011, 32'hDEAD_BEEF, 32'h1234_5678), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
